// File: rtl/decodificador_complemento7b_pkg.sv
// Shared constants for the 7-bit complement result decoder: widths, FSM
// encoding, shift-step terminal count and seven-segment digit patterns.
package decodificador_complemento7b_pkg;

    localparam int W_OPER = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAG,
        ST_SHIFT,
        ST_DONE
    } estado_t;

    localparam logic [2:0] STEP_LAST = 3'd6;

    // Bit i of each pattern drives segment i (0 = a ... 6 = g), active high.
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] seg_pattern(input logic [3:0] digito);
        case (digito)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/decodificador_complemento7b_7seg.sv
// BCD digit to active-high seven-segment pattern, index 0 = segment a.
module decodificador_7seg
    import decodificador_complemento7b_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [0:6] seg
);

    logic [6:0] padrao;

    assign padrao = seg_pattern(bcd);

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_seg
            assign seg[gi] = padrao[gi];
        end
    endgenerate

endmodule

// File: rtl/decodificador_complemento7b.sv
// Sequential decoder: complement result -> sign/magnitude -> two BCD digits
// by shift-and-add-3, driving the sign and digit seven-segment outputs.
module decodificador_complemento7b
    import decodificador_complemento7b_pkg::*;
#(
    parameter int N = W_OPER
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         modo,
    input  logic [0:N-1] valor,
    output logic         busy,
    output logic         done,
    output logic         neg,
    output logic [0:3]   dezena,
    output logic [0:3]   unidade,
    output logic [0:6]   seg_dez,
    output logic [0:6]   seg_uni,
    output logic         seg_sinal
);

    estado_t        state_reg, state_next;
    logic [N-1:0]   valor_num;
    logic [N-1:0]   valor_reg, valor_next;
    logic           modo_reg, modo_next;
    logic [N-1:0]   mag_reg, mag_next;
    logic [3:0]     dez_reg, dez_next;
    logic [3:0]     uni_reg, uni_next;
    logic [2:0]     step_reg, step_next;
    logic           neg_pend_reg, neg_pend_next;
    logic           neg_reg, neg_next;
    logic [3:0]     dez_out_reg, dez_out_next;
    logic [3:0]     uni_out_reg, uni_out_next;

    logic [N-1:0]   mag_calc;
    logic [3:0]     dez_adj, uni_adj;
    logic [N+7:0]   deslocado;

    // Port bit 0 is the LSB; map onto a conventional numeric vector.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_valor
            assign valor_num[gi] = valor[gi];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_digitos
            assign dezena[gi]  = dez_out_reg[gi];
            assign unidade[gi] = uni_out_reg[gi];
        end
    endgenerate

    // Two's complement of 1000000 wraps back to 1000000, read as unsigned 64.
    assign mag_calc = !valor_reg[N-1] ? valor_reg
                    : (modo_reg ? (~valor_reg + N'(1)) : ~valor_reg);

    assign dez_adj   = (dez_reg >= 4'd5) ? dez_reg + 4'd3 : dez_reg;
    assign uni_adj   = (uni_reg >= 4'd5) ? uni_reg + 4'd3 : uni_reg;
    assign deslocado = {dez_adj, uni_adj, mag_reg} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valor_reg    <= '0;
            modo_reg     <= 1'b0;
            mag_reg      <= '0;
            dez_reg      <= '0;
            uni_reg      <= '0;
            step_reg     <= '0;
            neg_pend_reg <= 1'b0;
            neg_reg      <= 1'b0;
            dez_out_reg  <= '0;
            uni_out_reg  <= '0;
        end else begin
            valor_reg    <= valor_next;
            modo_reg     <= modo_next;
            mag_reg      <= mag_next;
            dez_reg      <= dez_next;
            uni_reg      <= uni_next;
            step_reg     <= step_next;
            neg_pend_reg <= neg_pend_next;
            neg_reg      <= neg_next;
            dez_out_reg  <= dez_out_next;
            uni_out_reg  <= uni_out_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        valor_next    = valor_reg;
        modo_next     = modo_reg;
        mag_next      = mag_reg;
        dez_next      = dez_reg;
        uni_next      = uni_reg;
        step_next     = step_reg;
        neg_pend_next = neg_pend_reg;
        neg_next      = neg_reg;
        dez_out_next  = dez_out_reg;
        uni_out_next  = uni_out_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    valor_next = valor_num;
                    modo_next  = modo;
                    state_next = ST_MAG;
                end
            end
            ST_MAG: begin
                mag_next      = mag_calc;
                dez_next      = '0;
                uni_next      = '0;
                step_next     = '0;
                neg_pend_next = valor_reg[N-1] && (mag_calc != '0);
                state_next    = ST_SHIFT;
            end
            ST_SHIFT: begin
                mag_next  = deslocado[N-1:0];
                uni_next  = deslocado[N+3:N];
                dez_next  = deslocado[N+7:N+4];
                step_next = step_reg + 3'd1;
                // Results land on the edge entering DONE so they are valid with done.
                if (step_reg == STEP_LAST) begin
                    neg_next     = neg_pend_reg;
                    dez_out_next = deslocado[N+7:N+4];
                    uni_out_next = deslocado[N+3:N];
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign neg       = neg_reg;
    assign seg_sinal = neg_reg;

    decodificador_7seg u_seg_dez (
        .bcd (dez_out_reg),
        .seg (seg_dez)
    );

    decodificador_7seg u_seg_uni (
        .bcd (uni_out_reg),
        .seg (seg_uni)
    );

endmodule

// File: tb/tb_decodificador_complemento7b.sv
// Randomized self-checking bench for decodificador_complemento7b against an
// arithmetic reference model (signed value -> tens/units -> segment letters).
module tb_decodificador_complemento7b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       modo;
    logic [0:6] valor;
    logic       busy;
    logic       done;
    logic       neg;
    logic [0:3] dezena;
    logic [0:3] unidade;
    logic [0:6] seg_dez;
    logic [0:6] seg_uni;
    logic       seg_sinal;

    int n_vec = 0;
    int n_err = 0;

    decodificador_complemento7b #(.N(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .modo      (modo),
        .valor     (valor),
        .busy      (busy),
        .done      (done),
        .neg       (neg),
        .dezena    (dezena),
        .unidade   (unidade),
        .seg_dez   (seg_dez),
        .seg_uni   (seg_uni),
        .seg_sinal (seg_sinal)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input int obs, input int esp);
        n_vec++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
        end
    endtask

    // Signed value represented by a 7-bit word (v = 0..127).
    function automatic int valor_ref(input bit m, input int v);
        if (v < 64) return v;
        return m ? (v - 128) : (v - 127);
    endfunction

    function automatic logic [0:6] seg_ref(input int d);
        string letras [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                               "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
        logic [0:6] r = '0;
        string s = letras[d];
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    function automatic int nib(input logic [0:3] d);
        int r = 0;
        for (int i = 0; i < 4; i++) if (d[i]) r += (1 << i);
        return r;
    endfunction

    task automatic set_valor(input int v);
        for (int i = 0; i < 7; i++) valor[i] = v[i];
    endtask

    task automatic confere_saidas(input string tag, input int val);
        int mag = (val < 0) ? -val : val;
        verifica({tag, " neg"}, int'(neg), int'(val < 0));
        verifica({tag, " dezena"}, nib(dezena), mag / 10);
        verifica({tag, " unidade"}, nib(unidade), mag % 10);
        verifica({tag, " seg_dez"}, int'(seg_dez), int'(seg_ref(mag / 10)));
        verifica({tag, " seg_uni"}, int'(seg_uni), int'(seg_ref(mag % 10)));
        verifica({tag, " seg_sinal"}, int'(seg_sinal), int'(val < 0));
    endtask

    task automatic run_conv(input bit m, input int v, input string tag);
        int  val  = valor_ref(m, v);
        int  cyc  = 0;
        bit  seen = 0;
        @(negedge clk);
        start = 1'b1;
        modo  = m;
        set_valor(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        verifica({tag, " busy"}, int'(busy), 1);
        for (int c = 1; c <= 20 && !seen; c++) begin
            modo = 1'($urandom);
            set_valor(int'($urandom_range(0, 127)));
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                cyc  = c;
            end
        end
        verifica({tag, " latency"}, cyc, 8);
        $display("%s: modo=%0d valor=%0d -> %0d (neg=%0d dez=%0d uni=%0d)",
                 tag, m, v, val, neg, nib(dezena), nib(unidade));
        confere_saidas(tag, val);
        @(posedge clk);
        #1;
        verifica({tag, " done pulse"}, int'(done), 0);
        verifica({tag, " busy end"}, int'(busy), 0);
    endtask

    initial begin
        int done_edges[$];
        bit got_done;

        rst_n = 1'b0;
        start = 1'b0;
        modo  = 1'b0;
        set_valor(0);
        repeat (2) @(negedge clk);
        verifica("reset busy", int'(busy), 0);
        verifica("reset done", int'(done), 0);
        confere_saidas("reset", 0);
        rst_n = 1'b1;

        run_conv(1'b1, 64,  "min two");
        run_conv(1'b0, 127, "neg zero");
        run_conv(1'b0, 64,  "min ones");
        run_conv(1'b1, 63,  "max pos");
        run_conv(1'b1, 0,   "zero");
        for (int i = 0; i < 25; i++) begin
            run_conv(1'($urandom), int'($urandom_range(0, 127)), $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // start held high; valor changes mid-conversion.
        @(negedge clk);
        start = 1'b1;
        modo  = 1'b1;
        set_valor(42);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 4) set_valor(7);
            if (e == 10) verifica("held busy gap", int'(busy), 0);
            if (done) begin
                done_edges.push_back(e);
                $display("held: done at edge %0d dez=%0d uni=%0d", e, nib(dezena), nib(unidade));
                if (done_edges.size() == 1) begin
                    verifica("held first dez", nib(dezena), 4);
                    verifica("held first uni", nib(unidade), 2);
                end else begin
                    verifica("held second dez", nib(dezena), 0);
                    verifica("held second uni", nib(unidade), 7);
                end
            end
        end
        start = 1'b0;
        verifica("held done count", done_edges.size(), 2);
        if (done_edges.size() == 2) begin
            verifica("held first edge", done_edges[0], 9);
            verifica("held spacing", done_edges[1] - done_edges[0], 10);
        end
        repeat (3) @(negedge clk);

        // Leave non-reset outputs, then reset during SHIFT step 3.
        run_conv(1'b1, 123, "minus five");
        verifica("minus five seg_uni", int'(seg_uni), int'(7'b1011011));
        @(negedge clk);
        start = 1'b1;
        modo  = 1'b0;
        set_valor(45);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        verifica("abort busy", int'(busy), 0);
        verifica("abort done", int'(done), 0);
        confere_saidas("abort", 0);
        got_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) got_done = 1;
        end
        verifica("abort no done", int'(got_done), 0);
        rst_n = 1'b1;
        $display("reset mid-conversion released");
        run_conv(1'b1, 10, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
